m2vside3: RTL and testbench
===========================

// Module: m2vside3
// PURPOSE
//  MPEG2 side-information container, 3rd stage. Receives per-macroblock side info from stage 2
//  and walks the six 4:2:0 blocks (Y0..Y3, Cb, Cr) of that macroblock one at a time.
//  Presents per-block info (s3_*) that stage 4 latches on each block_start pulse.
//  One pending-macroblock slot decouples stage 2 from block timing.
// PARAMETERS
//  MBX_WIDTH  6  macroblock X address width
//  MBY_WIDTH  5  macroblock Y address width
// PORTS
//  clk          in   1          clock
//  reset_n      in   1          async reset, active low
//  s2_mb_x      in   MBX_WIDTH  macroblock X of incoming MB
//  s2_mb_y      in   MBY_WIDTH  macroblock Y of incoming MB
//  s2_mb_intra  in   1          incoming MB is intra
//  s2_cbp       in   6          coded_block_pattern; bit5 = block0 ... bit0 = block5
//  s2_enable    in   1          incoming MB is to be output (0 = skip output, still sequenced)
//  mb_start     in   1          1-cycle pulse: accept s2_* as a new macroblock
//  block_start  in   1          1-cycle pulse: stage 4 latches s3_* this edge; advance block
//  s3_mb_x      out  MBX_WIDTH  active MB X
//  s3_mb_y      out  MBY_WIDTH  active MB Y
//  s3_mb_intra  out  1          active MB intra
//  s3_block     out  3          current block index 0..5
//  s3_coded     out  1          current block has coefficients
//  s3_enable    out  1          active MB valid AND its s2_enable
//  s3_ready     out  1          pending slot free (mb_start will be accepted)
//  s3_mb_done   out  1          1-cycle pulse after block 5 consumed
//  s3_overflow  out  1          sticky: mb_start arrived while pending slot full
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0 except s3_ready=1; active and pending slots empty.
//  State: ACT_V (active valid), PND_V (pending valid), block counter 0..5. All outputs registered.
//  s3_coded = intra ? 1 : cbp[5-block]; s3_enable = ACT_V & act_enable. When ACT_V=0: s3_enable=0,
//   s3_block=0, other s3_mb_* hold last value.
//  mb_start, ACT_V=0 (or being freed same edge): s2_* -> active, block=0, ACT_V=1; outputs valid next cycle.
//  mb_start, ACT_V=1 and not freed, PND_V=0: s2_* -> pending, PND_V=1, s3_ready=0 next cycle.
//  mb_start with PND_V=1 and pending not moving this edge: input dropped, s3_overflow<=1 (sticky to reset).
//  block_start, ACT_V=1, block<5: block<=block+1.
//  block_start, ACT_V=1, block==5: s3_mb_done pulses next cycle; if PND_V: pending -> active, block=0,
//   PND_V=0; else if mb_start same edge: s2_* -> active directly; else ACT_V<=0.
//  Simultaneous block_start(block5) + mb_start with PND_V=1: pending -> active, s2_* -> pending (no overflow).
//  block_start with ACT_V=0: no state change (stage 4 latches enable=0).
//  Block counter never exceeds 5; wraps to 0 only via MB hand-over.
//  Reset asserted mid-macroblock: both slots discarded immediately, no s3_mb_done emitted.
// TESTING
//  1 Reset, mb_start x=3 y=2 intra=0 cbp=6'b101001 en=1, 6 block_starts -> s3_coded 1,0,1,0,0,1
//    for blocks 0..5; s3_mb_done one cycle after 6th block_start; s3_enable=0 afterwards.
//  2 Intra MB cbp=0 -> s3_coded=1 on all six blocks.
//  3 MB A active, mb_start B at block 2 -> s3_ready=0; after A's block 5 consumed, s3_mb_x=B next cycle,
//    block=0, s3_ready=1.
//  4 A active, B pending, mb_start C -> s3_overflow=1 and stays 1; C never appears; B follows A.
//  5 block_start(block5) and mb_start same cycle, PND_V=0 -> new MB at block 0 next cycle, no gap.
//  6 reset_n low at block 3 with pending MB -> next cycle s3_enable=0, s3_block=0, s3_ready=1,
//    no s3_mb_done; s2_enable=0 MB -> sequences 6 blocks with s3_enable=0.

Source files
------------

// File: rtl/m2vside3_if.sv
`default_nettype none
// ============================================================================
// Module : m2vside3_if
// Purpose: Signal bundle between stage 2, the stage-3 side-info container and
//          stage 4 of the MPEG2 pipeline.
// Ports  : s2_* / mb_start / block_start  -> into stage 3
//          s3_*                           <- out of stage 3
// Rev    : 1.0  initial release
// ============================================================================
interface m2vside3_if #(
  parameter int MBX_WIDTH = 6,
  parameter int MBY_WIDTH = 5
);
  logic [MBX_WIDTH-1:0] s2_mb_x;
  logic [MBY_WIDTH-1:0] s2_mb_y;
  logic                 s2_mb_intra;
  logic [5:0]           s2_cbp;
  logic                 s2_enable;
  logic                 mb_start;
  logic                 block_start;

  logic [MBX_WIDTH-1:0] s3_mb_x;
  logic [MBY_WIDTH-1:0] s3_mb_y;
  logic                 s3_mb_intra;
  logic [2:0]           s3_block;
  logic                 s3_coded;
  logic                 s3_enable;
  logic                 s3_ready;
  logic                 s3_mb_done;
  logic                 s3_overflow;

  // Stage-3 side of the bundle
  modport slave (
    input  s2_mb_x, s2_mb_y, s2_mb_intra, s2_cbp, s2_enable, mb_start, block_start,
    output s3_mb_x, s3_mb_y, s3_mb_intra, s3_block, s3_coded, s3_enable,
           s3_ready, s3_mb_done, s3_overflow
  );

  // Upstream/downstream (driver) side of the bundle
  modport master (
    output s2_mb_x, s2_mb_y, s2_mb_intra, s2_cbp, s2_enable, mb_start, block_start,
    input  s3_mb_x, s3_mb_y, s3_mb_intra, s3_block, s3_coded, s3_enable,
           s3_ready, s3_mb_done, s3_overflow
  );
endinterface
`default_nettype wire

// File: rtl/m2vside3.sv
`default_nettype none
// ============================================================================
// Module : m2vside3
// Purpose: MPEG2 side-information container, 3rd stage. Holds one active
//          macroblock plus one pending macroblock and walks the six 4:2:0
//          blocks (Y0..Y3, Cb, Cr) of the active one, advancing on each
//          block_start pulse from stage 4.
// Ports  : clk      - clock
//          reset_n  - asynchronous reset, active low
//          bus      - m2vside3_if.slave (s2_* inputs, mb_start, block_start,
//                     s3_* registered outputs)
// Rev    : 1.0  initial release
// ============================================================================
module m2vside3 #(
  parameter int MBX_WIDTH = 6,
  parameter int MBY_WIDTH = 5
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  m2vside3_if.slave   bus
);

  localparam logic [2:0] C_LAST_BLK = 3'd5;

  // Slot state
  logic                 r_act_v, r_pnd_v;
  logic [2:0]           r_blk;
  logic [MBX_WIDTH-1:0] r_act_x, r_pnd_x;
  logic [MBY_WIDTH-1:0] r_act_y, r_pnd_y;
  logic                 r_act_intra, r_pnd_intra;
  logic [5:0]           r_act_cbp, r_pnd_cbp;
  logic                 r_act_en, r_pnd_en;
  // Registered outputs that are not plain copies of slot state
  logic                 r_coded, r_enable, r_ready, r_done, r_ovf;

  // Next-state values
  logic                 w_act_v, w_pnd_v;
  logic [2:0]           w_blk;
  logic [MBX_WIDTH-1:0] w_act_x, w_pnd_x;
  logic [MBY_WIDTH-1:0] w_act_y, w_pnd_y;
  logic                 w_act_intra, w_pnd_intra;
  logic [5:0]           w_act_cbp, w_pnd_cbp;
  logic                 w_act_en, w_pnd_en;
  logic                 w_done, w_ovf, w_coded;
  logic                 w_last, w_free;
  logic [2:0]           w_idx;

  // Block 5 of the active MB is being consumed this edge
  assign w_last = r_act_v & bus.block_start & (r_blk == C_LAST_BLK);
  // Active slot is empty or is being vacated this edge
  assign w_free = ~r_act_v | w_last;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_act_v     = r_act_v;
    w_pnd_v     = r_pnd_v;
    w_blk       = r_blk;
    w_act_x     = r_act_x;
    w_act_y     = r_act_y;
    w_act_intra = r_act_intra;
    w_act_cbp   = r_act_cbp;
    w_act_en    = r_act_en;
    w_pnd_x     = r_pnd_x;
    w_pnd_y     = r_pnd_y;
    w_pnd_intra = r_pnd_intra;
    w_pnd_cbp   = r_pnd_cbp;
    w_pnd_en    = r_pnd_en;
    w_done      = w_last;
    w_ovf       = r_ovf;

    if (w_free) begin
      if (r_pnd_v) begin
        // Pending MB moves up; a simultaneous mb_start refills pending
        w_act_v     = 1'b1;
        w_blk       = 3'd0;
        w_act_x     = r_pnd_x;
        w_act_y     = r_pnd_y;
        w_act_intra = r_pnd_intra;
        w_act_cbp   = r_pnd_cbp;
        w_act_en    = r_pnd_en;
        w_pnd_v     = bus.mb_start;
        if (bus.mb_start) begin
          w_pnd_x     = bus.s2_mb_x;
          w_pnd_y     = bus.s2_mb_y;
          w_pnd_intra = bus.s2_mb_intra;
          w_pnd_cbp   = bus.s2_cbp;
          w_pnd_en    = bus.s2_enable;
        end
      end else if (bus.mb_start) begin
        // Straight into the active slot, no idle gap
        w_act_v     = 1'b1;
        w_blk       = 3'd0;
        w_act_x     = bus.s2_mb_x;
        w_act_y     = bus.s2_mb_y;
        w_act_intra = bus.s2_mb_intra;
        w_act_cbp   = bus.s2_cbp;
        w_act_en    = bus.s2_enable;
      end else begin
        w_act_v = 1'b0;
        w_blk   = 3'd0;
      end
    end else begin
      if (bus.block_start) begin
        w_blk = r_blk + 3'd1;
      end
      if (bus.mb_start) begin
        if (!r_pnd_v) begin
          w_pnd_v     = 1'b1;
          w_pnd_x     = bus.s2_mb_x;
          w_pnd_y     = bus.s2_mb_y;
          w_pnd_intra = bus.s2_mb_intra;
          w_pnd_cbp   = bus.s2_cbp;
          w_pnd_en    = bus.s2_enable;
        end else begin
          w_ovf = 1'b1;
        end
      end
    end
  end

  // cbp bit 5 belongs to block 0, bit 0 to block 5
  assign w_idx   = C_LAST_BLK - w_blk;
  assign w_coded = w_act_v & (w_act_intra | w_act_cbp[w_idx]);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_v     <= 1'b0;
      r_pnd_v     <= 1'b0;
      r_blk       <= 3'd0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_intra <= 1'b0;
      r_act_cbp   <= 6'd0;
      r_act_en    <= 1'b0;
      r_pnd_x     <= '0;
      r_pnd_y     <= '0;
      r_pnd_intra <= 1'b0;
      r_pnd_cbp   <= 6'd0;
      r_pnd_en    <= 1'b0;
      r_coded     <= 1'b0;
      r_enable    <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_act_v     <= w_act_v;
      r_pnd_v     <= w_pnd_v;
      r_blk       <= w_blk;
      r_act_x     <= w_act_x;
      r_act_y     <= w_act_y;
      r_act_intra <= w_act_intra;
      r_act_cbp   <= w_act_cbp;
      r_act_en    <= w_act_en;
      r_pnd_x     <= w_pnd_x;
      r_pnd_y     <= w_pnd_y;
      r_pnd_intra <= w_pnd_intra;
      r_pnd_cbp   <= w_pnd_cbp;
      r_pnd_en    <= w_pnd_en;
      r_coded     <= w_coded;
      r_enable    <= w_act_v & w_act_en;
      r_ready     <= ~w_pnd_v;
      r_done      <= w_done;
      r_ovf       <= w_ovf;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // --------------------------------------------------------------------------
  assign bus.s3_mb_x     = r_act_x;
  assign bus.s3_mb_y     = r_act_y;
  assign bus.s3_mb_intra = r_act_intra;
  assign bus.s3_block    = r_blk;
  assign bus.s3_coded    = r_coded;
  assign bus.s3_enable   = r_enable;
  assign bus.s3_ready    = r_ready;
  assign bus.s3_mb_done  = r_done;
  assign bus.s3_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_m2vside3.sv
`default_nettype none
// ============================================================================
// Module : tb_m2vside3
// Purpose: Directed self-checking bench for m2vside3.
// Rev    : 1.0  initial release
// ============================================================================
module tb_m2vside3;

  logic clk;
  logic reset_n;
  int   nvec;
  int   nerr;

  m2vside3_if #(.MBX_WIDTH(6), .MBY_WIDTH(5)) bus ();

  m2vside3 #(.MBX_WIDTH(6), .MBY_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mb(input logic [5:0] x, input logic [4:0] y, input logic intra,
                         input logic [5:0] cbp, input logic en);
    bus.s2_mb_x     = x;
    bus.s2_mb_y     = y;
    bus.s2_mb_intra = intra;
    bus.s2_cbp      = cbp;
    bus.s2_enable   = en;
    bus.mb_start    = 1'b1;
  endtask

  task automatic pulse_block(input int n);
    for (int i = 0; i < n; i++) begin
      bus.block_start = 1'b1;
      step();
      bus.block_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    nvec++; if (bus.s3_ready !== 1'b1)    begin nerr++; $display("FAIL rst_ready got %b exp 1", bus.s3_ready); end
    nvec++; if (bus.s3_enable !== 1'b0)   begin nerr++; $display("FAIL rst_enable got %b exp 0", bus.s3_enable); end
    nvec++; if (bus.s3_block !== 3'd0)    begin nerr++; $display("FAIL rst_block got %0d exp 0", bus.s3_block); end
    nvec++; if (bus.s3_mb_done !== 1'b0)  begin nerr++; $display("FAIL rst_done got %b exp 0", bus.s3_mb_done); end
    nvec++; if (bus.s3_overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b exp 0", bus.s3_overflow); end
    nvec++; if (bus.s3_coded !== 1'b0)    begin nerr++; $display("FAIL rst_coded got %b exp 0", bus.s3_coded); end
    nvec++; if (bus.s3_mb_x !== 6'd0)     begin nerr++; $display("FAIL rst_mbx got %0d exp 0", bus.s3_mb_x); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_cbp_walk();
    logic [5:0] pat;
    pat = 6'b101001;
    load_mb(6'd3, 5'd2, 1'b0, pat, 1'b1);
    step();
    bus.mb_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nvec++; if (bus.s3_block !== 3'(i))    begin nerr++; $display("FAIL walk_block got %0d exp %0d", bus.s3_block, i); end
      nvec++; if (bus.s3_coded !== pat[5-i]) begin nerr++; $display("FAIL walk_coded blk %0d got %b exp %b", i, bus.s3_coded, pat[5-i]); end
      nvec++; if (bus.s3_enable !== 1'b1)    begin nerr++; $display("FAIL walk_enable got %b exp 1", bus.s3_enable); end
      nvec++; if (bus.s3_mb_done !== 1'b0)   begin nerr++; $display("FAIL walk_early_done blk %0d", i); end
      pulse_block(1);
    end
    nvec++; if (bus.s3_mb_done !== 1'b1) begin nerr++; $display("FAIL walk_done got %b exp 1", bus.s3_mb_done); end
    nvec++; if (bus.s3_enable !== 1'b0)  begin nerr++; $display("FAIL walk_en_after got %b exp 0", bus.s3_enable); end
    nvec++; if (bus.s3_block !== 3'd0)   begin nerr++; $display("FAIL walk_blk_after got %0d exp 0", bus.s3_block); end
    nvec++; if (bus.s3_mb_x !== 6'd3 || bus.s3_mb_y !== 5'd2) begin nerr++; $display("FAIL walk_hold_xy got %0d/%0d exp 3/2", bus.s3_mb_x, bus.s3_mb_y); end
    step();
    nvec++; if (bus.s3_mb_done !== 1'b0) begin nerr++; $display("FAIL walk_done_pulse got %b exp 0", bus.s3_mb_done); end
    // extra block_start while idle must not move anything
    pulse_block(1);
    nvec++; if (bus.s3_block !== 3'd0 || bus.s3_mb_done !== 1'b0) begin nerr++; $display("FAIL idle_bs blk %0d done %b exp 0 0", bus.s3_block, bus.s3_mb_done); end
  endtask

  task automatic test_intra();
    load_mb(6'd11, 5'd4, 1'b1, 6'b000000, 1'b1);
    step();
    bus.mb_start = 1'b0;
    nvec++; if (bus.s3_mb_intra !== 1'b1) begin nerr++; $display("FAIL intra_flag got %b exp 1", bus.s3_mb_intra); end
    for (int i = 0; i < 6; i++) begin
      nvec++; if (bus.s3_coded !== 1'b1) begin nerr++; $display("FAIL intra_coded blk %0d got %b exp 1", i, bus.s3_coded); end
      pulse_block(1);
    end
    nvec++; if (bus.s3_mb_done !== 1'b1) begin nerr++; $display("FAIL intra_done got %b exp 1", bus.s3_mb_done); end
  endtask

  task automatic test_pending();
    load_mb(6'd10, 5'd1, 1'b0, 6'b111111, 1'b1);
    step();
    bus.mb_start = 1'b0;
    pulse_block(2);
    load_mb(6'd20, 5'd7, 1'b0, 6'b000001, 1'b1);
    step();
    bus.mb_start = 1'b0;
    nvec++; if (bus.s3_ready !== 1'b0) begin nerr++; $display("FAIL pnd_ready got %b exp 0", bus.s3_ready); end
    nvec++; if (bus.s3_mb_x !== 6'd10 || bus.s3_block !== 3'd2) begin nerr++; $display("FAIL pnd_active got x%0d b%0d exp x10 b2", bus.s3_mb_x, bus.s3_block); end
    pulse_block(3);
    nvec++; if (bus.s3_block !== 3'd5 || bus.s3_mb_x !== 6'd10) begin nerr++; $display("FAIL pnd_blk5 got x%0d b%0d exp x10 b5", bus.s3_mb_x, bus.s3_block); end
    pulse_block(1);
    nvec++; if (bus.s3_mb_done !== 1'b1) begin nerr++; $display("FAIL pnd_done got %b exp 1", bus.s3_mb_done); end
    nvec++; if (bus.s3_mb_x !== 6'd20 || bus.s3_mb_y !== 5'd7) begin nerr++; $display("FAIL pnd_handover got %0d/%0d exp 20/7", bus.s3_mb_x, bus.s3_mb_y); end
    nvec++; if (bus.s3_block !== 3'd0) begin nerr++; $display("FAIL pnd_blk0 got %0d exp 0", bus.s3_block); end
    nvec++; if (bus.s3_ready !== 1'b1) begin nerr++; $display("FAIL pnd_ready_back got %b exp 1", bus.s3_ready); end
    nvec++; if (bus.s3_coded !== 1'b0 || bus.s3_enable !== 1'b1) begin nerr++; $display("FAIL pnd_b_blk0 coded %b en %b exp 0 1", bus.s3_coded, bus.s3_enable); end
    pulse_block(5);
    nvec++; if (bus.s3_coded !== 1'b1) begin nerr++; $display("FAIL pnd_b_blk5 coded %b exp 1", bus.s3_coded); end
    pulse_block(1);
  endtask

  task automatic test_overflow();
    load_mb(6'd1, 5'd1, 1'b0, 6'b0, 1'b1);
    step();
    load_mb(6'd2, 5'd2, 1'b0, 6'b0, 1'b1);
    step();
    load_mb(6'd3, 5'd3, 1'b0, 6'b0, 1'b1);
    step();
    bus.mb_start = 1'b0;
    nvec++; if (bus.s3_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b exp 1", bus.s3_overflow); end
    nvec++; if (bus.s3_mb_x !== 6'd1) begin nerr++; $display("FAIL ovf_active got %0d exp 1", bus.s3_mb_x); end
    pulse_block(6);
    nvec++; if (bus.s3_mb_x !== 6'd2 || bus.s3_enable !== 1'b1) begin nerr++; $display("FAIL ovf_b_follows got x%0d en%b exp x2 en1", bus.s3_mb_x, bus.s3_enable); end
    pulse_block(6);
    nvec++; if (bus.s3_mb_done !== 1'b1 || bus.s3_mb_x !== 6'd2) begin nerr++; $display("FAIL ovf_b_done got done%b x%0d exp 1 x2", bus.s3_mb_done, bus.s3_mb_x); end
    step();
    nvec++; if (bus.s3_enable !== 1'b0 || bus.s3_mb_x !== 6'd2) begin nerr++; $display("FAIL ovf_c_absent got en%b x%0d exp 0 x2", bus.s3_enable, bus.s3_mb_x); end
    nvec++; if (bus.s3_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b exp 1", bus.s3_overflow); end
  endtask

  task automatic test_back_to_back();
    load_mb(6'd5, 5'd5, 1'b0, 6'b0, 1'b1);
    step();
    bus.mb_start = 1'b0;
    pulse_block(5);
    load_mb(6'd6, 5'd9, 1'b0, 6'b100000, 1'b1);
    bus.block_start = 1'b1;
    step();
    bus.block_start = 1'b0;
    bus.mb_start    = 1'b0;
    nvec++; if (bus.s3_mb_done !== 1'b1) begin nerr++; $display("FAIL b2b_done got %b exp 1", bus.s3_mb_done); end
    nvec++; if (bus.s3_mb_x !== 6'd6 || bus.s3_block !== 3'd0) begin nerr++; $display("FAIL b2b_new got x%0d b%0d exp x6 b0", bus.s3_mb_x, bus.s3_block); end
    nvec++; if (bus.s3_enable !== 1'b1 || bus.s3_coded !== 1'b1) begin nerr++; $display("FAIL b2b_en_coded got %b %b exp 1 1", bus.s3_enable, bus.s3_coded); end
    nvec++; if (bus.s3_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready got %b exp 1", bus.s3_ready); end
    pulse_block(6);
  endtask

  task automatic test_reset_mid_and_disabled();
    load_mb(6'd7, 5'd3, 1'b0, 6'b111111, 1'b1);
    step();
    load_mb(6'd8, 5'd4, 1'b0, 6'b111111, 1'b1);
    step();
    bus.mb_start = 1'b0;
    pulse_block(3);
    nvec++; if (bus.s3_block !== 3'd3 || bus.s3_ready !== 1'b0) begin nerr++; $display("FAIL mid_pre got b%0d rdy%b exp b3 rdy0", bus.s3_block, bus.s3_ready); end
    reset_n = 1'b0;
    #2;
    nvec++; if (bus.s3_block !== 3'd0) begin nerr++; $display("FAIL mid_async_blk got %0d exp 0", bus.s3_block); end
    step();
    nvec++; if (bus.s3_enable !== 1'b0 || bus.s3_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst got en%b rdy%b exp 0 1", bus.s3_enable, bus.s3_ready); end
    nvec++; if (bus.s3_overflow !== 1'b0) begin nerr++; $display("FAIL mid_ovf_clr got %b exp 0", bus.s3_overflow); end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++; if (bus.s3_mb_done !== 1'b0 || bus.s3_enable !== 1'b0) begin nerr++; $display("FAIL mid_quiet got done%b en%b exp 0 0", bus.s3_mb_done, bus.s3_enable); end
    end
    load_mb(6'd9, 5'd6, 1'b0, 6'b111111, 1'b0);
    step();
    bus.mb_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nvec++; if (bus.s3_block !== 3'(i) || bus.s3_enable !== 1'b0 || bus.s3_mb_x !== 6'd9) begin
        nerr++; $display("FAIL dis_walk got b%0d en%b x%0d exp b%0d en0 x9", bus.s3_block, bus.s3_enable, bus.s3_mb_x, i);
      end
      pulse_block(1);
    end
    nvec++; if (bus.s3_mb_done !== 1'b1) begin nerr++; $display("FAIL dis_done got %b exp 1", bus.s3_mb_done); end
  endtask

  initial begin
    nvec            = 0;
    nerr            = 0;
    reset_n         = 1'b0;
    bus.s2_mb_x     = '0;
    bus.s2_mb_y     = '0;
    bus.s2_mb_intra = 1'b0;
    bus.s2_cbp      = '0;
    bus.s2_enable   = 1'b0;
    bus.mb_start    = 1'b0;
    bus.block_start = 1'b0;
    #1;
    test_reset();
    test_cbp_walk();
    test_intra();
    test_pending();
    test_overflow();
    test_back_to_back();
    test_reset_mid_and_disabled();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
